// File: rtl/countdown_timer.sv
`default_nettype none
// ============================================================================
// Module      : countdown_timer
// Description : Loadable down-counter with valid/ready period load, ena-gated
//               decrement, abort, and a one-cycle done pulse on expiry.
//               Optional periodic auto-reload under COUNTDOWN_RELOAD_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module countdown_timer #(
    parameter  int T = 5000000,
    localparam int W = $clog2(T + 1)
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         ena,
    input  logic         load_valid,
    input  logic [W-1:0] load_value,
    output logic         load_ready,
    input  logic         abort,
`ifdef COUNTDOWN_RELOAD_EN
    input  logic         reload,
`endif
    output logic [W-1:0] count,
    output logic         busy,
    output logic         done
);

    localparam logic [W-1:0] c_tmax = W'(T);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_RUN    = 2'd1,
        S_EXPIRE = 2'd2
    } state_t;

    state_t       r_state;
    logic [W-1:0] r_count;
    logic         r_busy;
    logic         r_done;
    logic         r_load_ready;
    logic [W-1:0] w_load_clamped;
`ifdef COUNTDOWN_RELOAD_EN
    logic [W-1:0] r_period;
    logic         w_do_reload;
`endif

    assign w_load_clamped = (load_value > c_tmax) ? c_tmax : load_value;

`ifdef COUNTDOWN_RELOAD_EN
    assign w_do_reload = reload && !abort && (r_period != '0);
`endif

    // Outputs are registered alongside the state so they always match it.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state      <= S_IDLE;
            r_count      <= '0;
            r_busy       <= 1'b0;
            r_done       <= 1'b0;
            r_load_ready <= 1'b1;
`ifdef COUNTDOWN_RELOAD_EN
            r_period     <= '0;
`endif
        end else begin
            r_done <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (load_valid) begin
                        r_count      <= w_load_clamped;
                        r_busy       <= 1'b1;
                        r_load_ready <= 1'b0;
`ifdef COUNTDOWN_RELOAD_EN
                        r_period     <= w_load_clamped;
`endif
                        if (w_load_clamped != '0) begin
                            r_state <= S_RUN;
                        end else begin
                            r_state <= S_EXPIRE;
                            r_done  <= 1'b1;
                        end
                    end
                end
                S_RUN: begin
                    if (abort) begin
                        r_count      <= '0;
                        r_state      <= S_IDLE;
                        r_busy       <= 1'b0;
                        r_load_ready <= 1'b1;
                    end else if (ena) begin
                        if (r_count > W'(1)) begin
                            r_count <= r_count - W'(1);
                        end else begin
                            // Covers count==1; also a safe exit should count ever read 0.
                            r_count <= '0;
                            r_state <= S_EXPIRE;
                            r_done  <= 1'b1;
                        end
                    end
                end
                S_EXPIRE: begin
`ifdef COUNTDOWN_RELOAD_EN
                    if (w_do_reload) begin
                        r_count <= r_period;
                        r_state <= S_RUN;
                    end else begin
                        r_state      <= S_IDLE;
                        r_busy       <= 1'b0;
                        r_load_ready <= 1'b1;
                    end
`else
                    r_state      <= S_IDLE;
                    r_busy       <= 1'b0;
                    r_load_ready <= 1'b1;
`endif
                end
                default: begin
                    r_state      <= S_IDLE;
                    r_count      <= '0;
                    r_busy       <= 1'b0;
                    r_load_ready <= 1'b1;
                end
            endcase
        end
    end

    assign count      = r_count;
    assign busy       = r_busy;
    assign done       = r_done;
    assign load_ready = r_load_ready;

endmodule
`default_nettype wire
